// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - Systolic PE array pass controller: operand fetch, skewed valid feed, drain and completion.
module pe_array_ctrl #(
    parameter int N   = 4,
    parameter int AW  = 8,
    parameter int LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW-1:0]   k_len,
    input  logic [N*N-1:0]  pe_busy,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    output logic [N-1:0]    row_vld,
    output logic [N-1:0]    col_vld,
    output logic            pe_en,
    output logic            busy,
    output logic            done
);

    // Last skewed operand reaches the far corner after 2*(N-1) hops, then LAT to a result.
    localparam int DRAIN_CYC = 2 * (N - 1) + LAT + 1;
    localparam int DW        = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t          state, state_d;
    logic [AW-1:0]   cnt, cnt_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   k_q, k_d;
    logic [DW-1:0]   dcnt, dcnt_d;
    logic [N-1:0]    skew;
    logic            zero_start;
    logic            kill;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        dcnt_d     = dcnt;
        base_d     = base_q;
        k_d        = k_q;
        zero_start = 1'b0;
        kill       = abort && (state != IDLE);
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (k_len != '0) begin
                        state_d = FEED;
                        base_d  = base_addr;
                        k_d     = k_len;
                        cnt_d   = '0;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            FEED: begin
                if (cnt == k_q - 1'b1) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    dcnt_d  = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DRAIN: begin
                // Hold at expiry until the array reports every PE idle.
                if (dcnt == DW'(DRAIN_CYC - 1)) begin
                    if (pe_busy == '0) begin
                        state_d = DONE;
                    end
                end else begin
                    dcnt_d = dcnt + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
            dcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            dcnt    <= '0;
            base_q  <= '0;
            k_q     <= '0;
            skew    <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            pe_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            dcnt    <= dcnt_d;
            base_q  <= base_d;
            k_q     <= k_d;
            // Stage 0 covers RAM read latency; stage i adds the systolic skew for row/column i.
            skew    <= kill ? '0 : {skew[N-2:0], rd_en};
            rd_en   <= (state_d == FEED);
            rd_addr <= (state_d == FEED) ? (base_d + cnt_d) : '0;
            pe_en   <= (state_d == FEED) || (state_d == DRAIN);
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE) || zero_start;
        end
    end

    assign row_vld = skew;
    assign col_vld = skew;

endmodule

// File: doc/pe_array_ctrl.md
PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 Parameter N, default 4: PE array dimension (N rows x N columns).
REQ-002 Parameter AW, default 8: operand RAM address width.
REQ-003 Parameter LAT, default 2: cycles from PE operand valid to result valid (multiplier plus result register).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to run one pass; sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of the current pass.
REQ-008 base_addr  input  AW  first RAM address of the pass; latched on accepted start.
REQ-009 k_len  input  AW  number of operand vectors to stream; latched on accepted start.
REQ-010 pe_busy  input  N*N  OR-able pe_doing flags from the array.
REQ-011 rd_en  output  1  RAM read strobe for both operand RAMs.
REQ-012 rd_addr  output  AW  RAM read address.
REQ-013 row_vld  output  N  per-row in0_vld feed; bit i is skewed by i cycles.
REQ-014 col_vld  output  N  per-column in1_vld feed; bit j is skewed by j cycles.
REQ-015 pe_en  output  1  array-wide PE enable.
REQ-016 busy  output  1  high from accepted start until done or abort.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 The FSM states SHALL be IDLE, FEED, DRAIN and DONE, encoded in registers.
REQ-019 IDLE: a start with k_len != 0 SHALL latch base_addr and k_len, clear cnt, and enter FEED on the next edge.
REQ-020 IDLE: a start with k_len == 0 SHALL pulse done on the next cycle, leave busy low and stay in IDLE.
REQ-021 A start outside IDLE SHALL be ignored, with no queuing.
REQ-022 FEED: rd_en SHALL be 1 and rd_addr SHALL be (base_addr + cnt) mod 2^AW, with cnt running 0..k_len-1 one per cycle.
- Wrap-around past 2^AW-1 is legal.
REQ-023 FEED: after the cycle with cnt == k_len-1, the FSM SHALL enter DRAIN, so rd_en is high for exactly k_len cycles.
REQ-024 A rd_en pulse in cycle t SHALL produce row_vld[i] and col_vld[i] high in cycle t+1+i.
- This covers the 1-cycle RAM read latency plus the systolic skew.
- Build it as a shift register of depth N.
REQ-025 DRAIN: a drain counter SHALL count 2*(N-1)+LAT+1 cycles from DRAIN entry.
REQ-026 DRAIN SHALL exit to DONE only when the drain counter has expired AND pe_busy == 0; otherwise it waits indefinitely.
REQ-027 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-028 pe_en SHALL be 1 in FEED and DRAIN and 0 in IDLE and DONE.
REQ-029 busy SHALL be 1 in FEED, DRAIN and DONE.
REQ-030 abort in FEED, DRAIN or DONE SHALL:
- return the FSM to IDLE on the next edge;
- clear cnt, the drain counter and the skew shift registers;
- suppress done.
REQ-031 abort in IDLE SHALL have no effect, and abort takes priority over a simultaneous start.
REQ-032 rd_en, row_vld, col_vld, pe_en, busy and done SHALL all be register outputs.

Reset
REQ-033 While rst_n = 0, the following SHALL be forced to their reset values:
- state = IDLE;
- cnt, drain counter, skew registers, latched base_addr and k_len = 0;
- all outputs = 0.
REQ-034 Reset asserted mid-pass SHALL abandon the pass with no done pulse, and the first start after release SHALL be accepted normally.

Verification
REQ-035 N=4, LAT=2, start with base_addr=0x10 and k_len=3 -> rd_en high 3 cycles (addr 0x10, 0x11, 0x12); row_vld[3] high 4 cycles after rd_en; done 2*3+2+1=9 drain cycles after FEED ends (pe_busy=0).
REQ-036 base_addr=0xFE, k_len=4 -> rd_addr sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-037 k_len=0 start -> single done pulse next cycle; busy, rd_en and pe_en remain 0.
REQ-038 pe_busy held nonzero 5 cycles past drain expiry -> done delayed exactly 5 cycles; pe_en stays 1 throughout.
REQ-039 abort in the 2nd FEED cycle -> next cycle: all outputs 0, no done; a following start runs a full correct pass.
REQ-040 rst_n pulsed low during DRAIN -> outputs immediately 0; a start after release produces the normal sequence of REQ-035.
